// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - 7-segment decode constants and digit helpers for seg_scan_counter
package seg7_pkg;

    localparam logic [6:0] SEG7_0     = 7'h3F;
    localparam logic [6:0] SEG7_1     = 7'h06;
    localparam logic [6:0] SEG7_2     = 7'h5B;
    localparam logic [6:0] SEG7_3     = 7'h4F;
    localparam logic [6:0] SEG7_4     = 7'h66;
    localparam logic [6:0] SEG7_5     = 7'h6D;
    localparam logic [6:0] SEG7_6     = 7'h7D;
    localparam logic [6:0] SEG7_7     = 7'h07;
    localparam logic [6:0] SEG7_8     = 7'h7F;
    localparam logic [6:0] SEG7_9     = 7'h67;
    localparam logic [6:0] SEG7_BLANK = 7'h00;

    // Segment order is {g,f,e,d,c,b,a}; non-decimal codes render dark.
    function automatic logic [6:0] seg7_decode(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'd0:    seg = SEG7_0;
            4'd1:    seg = SEG7_1;
            4'd2:    seg = SEG7_2;
            4'd3:    seg = SEG7_3;
            4'd4:    seg = SEG7_4;
            4'd5:    seg = SEG7_5;
            4'd6:    seg = SEG7_6;
            4'd7:    seg = SEG7_7;
            4'd8:    seg = SEG7_8;
            4'd9:    seg = SEG7_9;
            default: seg = SEG7_BLANK;
        endcase
        return seg;
    endfunction

    // Time-style counting makes odd digits (tens of seconds/minutes) wrap at 5.
    function automatic logic [3:0] digit_max(input int idx, input logic time_mode);
        return (time_mode && idx[0]) ? 4'd5 : 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - single cascaded counter digit with configurable wrap value
module bcd_digit_cell
    import seg7_pkg::*;
(
    input  logic       mclk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc_in,
    input  logic [3:0] max_val,
    output logic [3:0] value,
    output logic       at_max
);

    logic [3:0] value_q;
    logic [3:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 4'd0;
        end else if (inc_in) begin
            value_d = at_max ? 4'd0 : value_q + 4'd1;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value  = value_q;
    assign at_max = (value_q == max_val);

endmodule

// File: rtl/seg_scan_counter.sv
// rtl/seg_scan_counter.sv - N-digit cascaded counter with multiplexed 7-segment scan output
module seg_scan_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CNT_DIV    = 50_000_000,
    parameter int SCAN_DIV   = 50_000,
    parameter int TIME_MODE  = 0,
    parameter int BLANK_LZ   = 0
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    output logic [NUM_DIGITS-1:0] seg_com,
    output logic [7:0]            seg_data,
    output logic                  carry_out
);

    localparam int PW = $clog2(CNT_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]         pre_q, pre_d;
    logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]         scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0] seg_com_q, seg_com_d;
    logic [7:0]            seg_data_q, seg_data_d;
    logic                  carry_q, carry_d;

    logic                  tick;
    logic                  scan_last;
    logic [NUM_DIGITS-1:0] inc;
    logic [NUM_DIGITS-1:0] at_max;
    logic [NUM_DIGITS-1:0] blank;
    logic [3:0]            digit_val [NUM_DIGITS];

    always_comb begin
        tick  = en && (pre_q == PW'(CNT_DIV - 1));
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end
    end

    // Ripple enable: a digit advances only when the tick propagates through all lower digits at max.
    always_comb begin
        logic run;
        run = tick;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            inc[i] = run;
            run    = run & at_max[i];
        end
        carry_d = tick && (&at_max) && !clr;
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        localparam logic [3:0] MAX_VAL = digit_max(g, TIME_MODE != 0);
        bcd_digit_cell u_cell (
            .mclk    (mclk),
            .rst     (rst),
            .clr     (clr),
            .inc_in  (inc[g]),
            .max_val (MAX_VAL),
            .value   (digit_val[g]),
            .at_max  (at_max[g])
        );
    end

    always_comb begin
        scan_last  = (scan_cnt_q == SW'(SCAN_DIV - 1));
        scan_cnt_d = scan_last ? '0 : scan_cnt_q + SW'(1);
        scan_idx_d = scan_idx_q;
        if (scan_last) begin
            scan_idx_d = (scan_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
        end
    end

    // Walk from the most significant digit down; a digit is blank while everything above it is zero too.
    always_comb begin
        logic hz;
        hz    = 1'b1;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            hz       = hz & (digit_val[i] == 4'd0);
            blank[i] = (BLANK_LZ != 0) && (i > 0) && hz;
        end
    end

    always_comb begin
        logic [3:0] cur_val;
        logic       cur_blank;
        logic       dp;
        seg_com_d = '1;
        cur_val   = 4'd0;
        cur_blank = 1'b0;
        dp        = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IW'(i)) begin
                seg_com_d[NUM_DIGITS-1-i] = 1'b0;
                cur_val   = digit_val[i];
                cur_blank = blank[i];
                dp        = (TIME_MODE != 0) && (i == 2);
            end
        end
        seg_data_d = cur_blank ? 8'h00 : {dp, seg7_decode(cur_val)};
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            pre_q      <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            seg_com_q  <= '1;
            seg_data_q <= 8'h00;
            carry_q    <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            seg_com_q  <= seg_com_d;
            seg_data_q <= seg_data_d;
            carry_q    <= carry_d;
        end
    end

    assign seg_com   = seg_com_q;
    assign seg_data  = seg_data_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_seg_scan_counter.sv
// tb/tb_seg_scan_counter.sv - directed self-checking bench for seg_scan_counter
module tb_seg_scan_counter;

    logic       mclk = 1'b0;
    logic       rst;
    logic       en0, en1, en2;
    logic       clr0, clr1, clr2;
    logic [3:0] com0, com1, com2;
    logic [7:0] dat0, dat1, dat2;
    logic       co0, co1, co2;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h67};
    logic [3:0] rot [4]  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    always #5 mclk = ~mclk;

    seg_scan_counter #(.NUM_DIGITS(4), .CNT_DIV(4), .SCAN_DIV(2), .TIME_MODE(0), .BLANK_LZ(0)) u_dec (
        .mclk(mclk), .rst(rst), .en(en0), .clr(clr0), .seg_com(com0), .seg_data(dat0), .carry_out(co0));
    seg_scan_counter #(.NUM_DIGITS(4), .CNT_DIV(4), .SCAN_DIV(2), .TIME_MODE(1), .BLANK_LZ(0)) u_time (
        .mclk(mclk), .rst(rst), .en(en1), .clr(clr1), .seg_com(com1), .seg_data(dat1), .carry_out(co1));
    seg_scan_counter #(.NUM_DIGITS(4), .CNT_DIV(4), .SCAN_DIV(2), .TIME_MODE(0), .BLANK_LZ(1)) u_blank (
        .mclk(mclk), .rst(rst), .en(en2), .clr(clr2), .seg_com(com2), .seg_data(dat2), .carry_out(co2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] com_of(input int w);
        return (w == 0) ? com0 : (w == 1) ? com1 : com2;
    endfunction

    function automatic logic [7:0] data_of(input int w);
        return (w == 0) ? dat0 : (w == 1) ? dat1 : dat2;
    endfunction

    task automatic set_en(input int w, input logic v);
        case (w)
            0:       en0 = v;
            1:       en1 = v;
            default: en2 = v;
        endcase
    endtask

    task automatic run_en(input int w, input int n);
        set_en(w, 1'b1);
        repeat (n) @(negedge mclk);
        set_en(w, 1'b0);
    endtask

    // Wait (bounded) for digit idx to be selected, then compare its segment code.
    task automatic show(input int w, input int idx, input logic [7:0] exp, input string tag);
        logic [3:0] want;
        logic       found;
        want        = 4'b1111;
        want[3-idx] = 1'b0;
        found       = 1'b0;
        @(negedge mclk);
        for (int i = 0; i < 20 && !found; i++) begin
            if (com_of(w) == want) found = 1'b1;
            else @(negedge mclk);
        end
        check({tag, "_sel"}, 32'(found), 32'd1);
        check(tag, 32'(data_of(w)), 32'(exp));
    endtask

    initial begin
        logic [3:0] prev;
        logic       found;
        rst = 1'b1;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;

        repeat (3) @(negedge mclk);
        check("rst_com", 32'(com0), 32'hF);
        check("rst_data", 32'(dat0), 32'h00);
        check("rst_carry", 32'(co0), 32'd0);
        rst = 1'b0;
        @(negedge mclk);
        check("first_com", 32'(com0), 32'b0111);
        check("first_data", 32'(dat0), 32'h3F);

        show(2, 3, 8'h00, "blk0_d3");
        show(2, 2, 8'h00, "blk0_d2");
        show(2, 1, 8'h00, "blk0_d1");
        show(2, 0, 8'h3F, "blk0_d0");

        for (int k = 1; k <= 10; k++) begin
            run_en(0, 4);
            show(0, 0, tab[k % 10], $sformatf("dec_d0_%0d", k));
        end
        show(0, 1, 8'h06, "dec_d1");

        run_en(1, 3599 * 4);
        show(1, 0, 8'h67, "tm_5959_d0");
        show(1, 1, 8'h6D, "tm_5959_d1");
        show(1, 2, 8'hE7, "tm_5959_d2");
        show(1, 3, 8'h6D, "tm_5959_d3");
        en1 = 1'b1;
        repeat (3) @(negedge mclk);
        check("tm_carry_pre", 32'(co1), 32'd0);
        @(negedge mclk);
        check("tm_carry_hi", 32'(co1), 32'd1);
        en1 = 1'b0;
        @(negedge mclk);
        check("tm_carry_lo", 32'(co1), 32'd0);
        show(1, 0, 8'h3F, "tm_0000_d0");
        show(1, 1, 8'h3F, "tm_0000_d1");
        show(1, 2, 8'hBF, "tm_0000_d2");
        show(1, 3, 8'h3F, "tm_0000_d3");

        clr0 = 1'b1;
        @(negedge mclk);
        clr0 = 1'b0;
        show(0, 1, 8'h3F, "clr_d1");
        run_en(0, 36);
        show(0, 0, 8'h67, "pre9_d0");
        en0 = 1'b1;
        repeat (3) @(negedge mclk);
        clr0 = 1'b1;
        @(negedge mclk);
        clr0 = 1'b0;
        en0  = 1'b0;
        check("clrtick_carry", 32'(co0), 32'd0);
        show(0, 0, 8'h3F, "clrtick_d0");
        show(0, 1, 8'h3F, "clrtick_d1");
        run_en(0, 3);
        show(0, 0, 8'h3F, "restart3_d0");
        run_en(0, 1);
        show(0, 0, 8'h06, "restart4_d0");

        run_en(0, 2);
        clr0 = 1'b1;
        @(negedge mclk);
        clr0 = 1'b0;
        run_en(0, 3);
        show(0, 0, 8'h3F, "midclr3_d0");
        run_en(0, 1);
        show(0, 0, 8'h06, "midclr4_d0");

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            prev = com0;
            @(negedge mclk);
            if (prev == 4'b1110 && com0 == 4'b0111) found = 1'b1;
        end
        check("rot_align", 32'(found), 32'd1);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("rot_%0d", k), 32'(com0), 32'(rot[(k / 2) % 4]));
            @(negedge mclk);
        end
        show(0, 0, 8'h06, "frozen_d0");
        show(0, 1, 8'h3F, "frozen_d1");

        run_en(2, 42 * 4);
        show(2, 3, 8'h00, "blk42_d3");
        show(2, 2, 8'h00, "blk42_d2");
        show(2, 1, 8'h66, "blk42_d1");
        show(2, 0, 8'h5B, "blk42_d0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
